// File: rtl/mbus_power_sequencer.sv
// Timed power-domain sequencer for one MBus layer: orders MBC_SLEEP/ISOLATE/RESET
// on sleep entry and wake-up, merges wake sources and records the wake cause.
module mbus_power_sequencer #(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 4,
    parameter int ISO_DLY = 2,
    parameter int RST_DLY = 2,
    parameter int PWR_DLY = 4
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               SLEEP_REQ,
    input  logic [NUM_REQ-1:0] WAKEUP_REQ,
    input  logic               MBUS_DIN,
    output logic               MBC_SLEEP,
    output logic               MBC_ISOLATE,
    output logic               MBC_RESET,
    output logic               SYSTEM_ACTIVE,
    output logic [NUM_REQ:0]   WAKE_SRC
);

    typedef enum logic [2:0] {
        ST_ACTIVE,
        ST_ENTER_ISO,
        ST_ENTER_RST,
        ST_SLEEP,
        ST_WAKE_PWR,
        ST_WAKE_ISO
    } state_t;

    localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_DLY - 1);
    localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_DLY - 1);
    localparam logic [CNT_W-1:0] PWR_LD = CNT_W'(PWR_DLY - 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [NUM_REQ:0]   pend, pend_nx;
    logic [NUM_REQ:0]   src_nx;
    logic [NUM_REQ:0]   wake_vec;
    logic               wake_evt;
    logic [2:0]         ctl_nx;
    logic               act_nx;

    // Bus activity is an active-low wake source placed above the request bits.
    assign wake_vec = {~MBUS_DIN, WAKEUP_REQ};
    assign wake_evt = |wake_vec;

    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        pend_nx  = pend;
        src_nx   = WAKE_SRC;
        case (state)
            ST_ACTIVE: begin
                if (SLEEP_REQ && !wake_evt) begin
                    state_nx = ST_ENTER_ISO;
                    cnt_nx   = ISO_LD;
                    src_nx   = '0;
                end
            end
            ST_ENTER_ISO: begin
                pend_nx = pend | wake_vec;
                if (cnt == '0) begin
                    state_nx = ST_ENTER_RST;
                    cnt_nx   = RST_LD;
                end
            end
            ST_ENTER_RST: begin
                pend_nx = pend | wake_vec;
                if (cnt == '0) begin
                    state_nx = ST_SLEEP;
                    cnt_nx   = '0;
                end
            end
            ST_SLEEP: begin
                if (wake_evt || (pend != '0)) begin
                    state_nx = ST_WAKE_PWR;
                    cnt_nx   = PWR_LD;
                    src_nx   = wake_vec | pend;
                    pend_nx  = '0;
                end
            end
            ST_WAKE_PWR: begin
                if (cnt == '0) begin
                    state_nx = ST_WAKE_ISO;
                    cnt_nx   = ISO_LD;
                end
            end
            ST_WAKE_ISO: begin
                if (cnt == '0) begin
                    state_nx = ST_ACTIVE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_SLEEP;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        ctl_nx = 3'b111;
        act_nx = 1'b0;
        case (state_nx)
            ST_ACTIVE:    begin ctl_nx = 3'b000; act_nx = 1'b1; end
            ST_ENTER_ISO: ctl_nx = 3'b010;
            ST_ENTER_RST: ctl_nx = 3'b011;
            ST_SLEEP:     ctl_nx = 3'b111;
            ST_WAKE_PWR:  ctl_nx = 3'b011;
            ST_WAKE_ISO:  ctl_nx = 3'b001;
            default:      ctl_nx = 3'b111;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state         <= ST_SLEEP;
            cnt           <= '0;
            pend          <= '0;
            WAKE_SRC      <= '0;
            MBC_SLEEP     <= 1'b1;
            MBC_ISOLATE   <= 1'b1;
            MBC_RESET     <= 1'b1;
            SYSTEM_ACTIVE <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            pend          <= pend_nx;
            WAKE_SRC      <= src_nx;
            MBC_SLEEP     <= ctl_nx[2];
            MBC_ISOLATE   <= ctl_nx[1];
            MBC_RESET     <= ctl_nx[0];
            SYSTEM_ACTIVE <= act_nx;
        end
    end

    a_sleep_gated: assert property (@(posedge CLK) disable iff (!RESETn)
        MBC_SLEEP |-> (MBC_ISOLATE && MBC_RESET));
    a_iso_release: assert property (@(posedge CLK) disable iff (!RESETn)
        !MBC_ISOLATE |-> !MBC_SLEEP);
    a_active_clear: assert property (@(posedge CLK) disable iff (!RESETn)
        SYSTEM_ACTIVE |-> !(MBC_SLEEP || MBC_ISOLATE || MBC_RESET));

endmodule
